// File: rtl/pr_skid_stage.sv
// pr_skid_stage: reusable valid/ready pipeline-stage register.
// Optional 2-entry skid, flush, bubble ctrl clear, stall counter.
//
// Ports:
//   CLK, RESET        rising-edge clock, async active-high reset
//   FLUSH             squash held entries and same-cycle input
//   IN_VALID/READY    upstream handshake, IN_DATA/IN_CTRL payload
//   OUT_VALID/READY   downstream handshake, OUT_DATA/OUT_CTRL head
//   OCCUPANCY         entries held (0..2)
//   STALL_CNT         saturating count of stalled output cycles
module pr_skid_stage #(
  parameter int DATA_WIDTH = 96,
  parameter int CTRL_WIDTH = 16,
  parameter int SKID       = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FLUSH,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic [CTRL_WIDTH-1:0] IN_CTRL,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic [CTRL_WIDTH-1:0] OUT_CTRL,
  output logic [1:0]            OCCUPANCY,
  output logic [CNT_WIDTH-1:0]  STALL_CNT
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state;
  logic                  out_valid_q;
  logic                  in_rdy_q;
  logic [DATA_WIDTH-1:0] main_data;
  logic [CTRL_WIDTH-1:0] main_ctrl;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [CTRL_WIDTH-1:0] skid_ctrl;
  logic [CNT_WIDTH-1:0]  stall_cnt;
  logic                  push;
  logic                  pop;

  assign pop  = out_valid_q & OUT_READY;
  assign push = IN_VALID & IN_READY & ~FLUSH;

  // Skid mode breaks the ready path with a flop; single-entry
  // mode lets OUT_READY through combinationally.
  if (SKID != 0) begin : g_skid
    assign IN_READY = in_rdy_q;
  end else begin : g_pass
    assign IN_READY = ~out_valid_q | OUT_READY;
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = main_data;
  assign OUT_CTRL  = main_ctrl;
  assign OCCUPANCY = 2'(state);
  assign STALL_CNT = stall_cnt;

  // Ctrl is zeroed on every path to EMPTY so bubbles carry no
  // write enables; data is left alone to avoid toggling.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      in_rdy_q    <= 1'b1;
      main_data   <= '0;
      main_ctrl   <= '0;
      skid_data   <= '0;
      skid_ctrl   <= '0;
    end else if (FLUSH) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      in_rdy_q    <= 1'b1;
      main_ctrl   <= '0;
      skid_ctrl   <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            main_data   <= IN_DATA;
            main_ctrl   <= IN_CTRL;
            out_valid_q <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          unique case (1'b1)
            push & pop: begin
              main_data <= IN_DATA;
              main_ctrl <= IN_CTRL;
            end
            push & ~pop: begin
              skid_data <= IN_DATA;
              skid_ctrl <= IN_CTRL;
              in_rdy_q  <= 1'b0;
              state     <= FULL;
            end
            ~push & pop: begin
              out_valid_q <= 1'b0;
              main_ctrl   <= '0;
              state       <= EMPTY;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (pop) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
            skid_ctrl <= '0;
            in_rdy_q  <= 1'b1;
            state     <= ONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          main_ctrl   <= '0;
          in_rdy_q    <= 1'b1;
          state       <= EMPTY;
        end
      endcase
    end
  end

  // Flush does not touch the counter; only reset clears it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_cnt <= '0;
    end else if (out_valid_q & ~OUT_READY & ~&stall_cnt) begin
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pr_skid_stage.sv
// tb_pr_skid_stage: scoreboard bench for pr_skid_stage.
// Skid instance (CNT_WIDTH=4) and single-entry instance.
module tb_pr_skid_stage;

  localparam int DW = 96;
  localparam int CW = 16;
  localparam logic [DW-1:0] D0 = {32'h1, 32'h0, 32'h3};
  localparam logic [DW-1:0] DA = {32'hA, 32'hA, 32'hA};
  localparam logic [DW-1:0] DB = {32'hB, 32'hB, 32'hB};
  localparam logic [DW-1:0] DC = {32'hC, 32'hC, 32'hC};
  localparam logic [DW-1:0] DE = {32'hE, 32'hE, 32'hE};

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  logic          s_flush = 1'b0;
  logic          s_iv = 1'b0;
  logic          s_ird;
  logic [DW-1:0] s_id = '0;
  logic [CW-1:0] s_ic = '0;
  logic          s_ov;
  logic          s_ord = 1'b0;
  logic [DW-1:0] s_od;
  logic [CW-1:0] s_oc;
  logic [1:0]    s_occ;
  logic [3:0]    s_cnt;

  logic          p_flush = 1'b0;
  logic          p_iv = 1'b0;
  logic          p_ird;
  logic [DW-1:0] p_id = '0;
  logic [CW-1:0] p_ic = '0;
  logic          p_ov;
  logic          p_ord = 1'b0;
  logic [DW-1:0] p_od;
  logic [CW-1:0] p_oc;
  logic [1:0]    p_occ;
  logic [15:0]   p_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [DW+CW-1:0] sq[$];
  logic [DW+CW-1:0] pq[$];
  logic [DW+CW-1:0] se;
  logic [DW+CW-1:0] pe;

  pr_skid_stage #(
    .DATA_WIDTH(DW), .CTRL_WIDTH(CW),
    .SKID(1), .CNT_WIDTH(4)
  ) u_skid (
    .CLK(CLK), .RESET(RESET), .FLUSH(s_flush),
    .IN_VALID(s_iv), .IN_READY(s_ird),
    .IN_DATA(s_id), .IN_CTRL(s_ic),
    .OUT_VALID(s_ov), .OUT_READY(s_ord),
    .OUT_DATA(s_od), .OUT_CTRL(s_oc),
    .OCCUPANCY(s_occ), .STALL_CNT(s_cnt)
  );

  pr_skid_stage #(
    .DATA_WIDTH(DW), .CTRL_WIDTH(CW),
    .SKID(0), .CNT_WIDTH(16)
  ) u_pass (
    .CLK(CLK), .RESET(RESET), .FLUSH(p_flush),
    .IN_VALID(p_iv), .IN_READY(p_ird),
    .IN_DATA(p_id), .IN_CTRL(p_ic),
    .OUT_VALID(p_ov), .OUT_READY(p_ord),
    .OUT_DATA(p_od), .OUT_CTRL(p_oc),
    .OCCUPANCY(p_occ), .STALL_CNT(p_cnt)
  );

  // Scoreboards: pops compared against queue heads, pushes enqueued.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sq.delete();
      pq.delete();
      exp_cnt = 0;
    end else begin
      if (s_ov && !s_ord && exp_cnt < 15) exp_cnt++;
      if (s_ov && s_ord) begin
        checks++;
        if (sq.size() == 0) begin
          errors++;
          $display("FAIL skid_pop: extra entry %h", s_od);
        end else begin
          se = sq.pop_front();
          if ({s_od, s_oc} !== se) begin
            errors++;
            $display("FAIL skid_pop: got %h/%h want %h",
                     s_od, s_oc, se);
          end
        end
      end
      if (s_flush) sq.delete();
      else if (s_iv && s_ird) sq.push_back({s_id, s_ic});

      if (p_ov && p_ord) begin
        checks++;
        if (pq.size() == 0) begin
          errors++;
          $display("FAIL pass_pop: extra entry %h", p_od);
        end else begin
          pe = pq.pop_front();
          if ({p_od, p_oc} !== pe) begin
            errors++;
            $display("FAIL pass_pop: got %h/%h want %h",
                     p_od, p_oc, pe);
          end
        end
      end
      if (p_flush) pq.delete();
      else if (p_iv && p_ird) pq.push_back({p_id, p_ic});
    end
  end

  // State invariants against the scoreboard, sampled mid-cycle.
  always @(negedge CLK) begin
    if (!RESET) begin
      checks++;
      if (s_occ !== 2'(sq.size()) || sq.size() > 2) begin
        errors++;
        $display("FAIL skid_occ: got %0d want %0d",
                 s_occ, sq.size());
      end
      checks++;
      if (s_ov !== (sq.size() != 0)) begin
        errors++;
        $display("FAIL skid_valid: got %b want %0d",
                 s_ov, sq.size() != 0);
      end
      checks++;
      if (s_ird !== (sq.size() < 2)) begin
        errors++;
        $display("FAIL skid_ready: got %b want %0d",
                 s_ird, sq.size() < 2);
      end
      if (s_ov === 1'b0) begin
        checks++;
        if (s_oc !== '0) begin
          errors++;
          $display("FAIL skid_bubble_ctrl: got %h want 0", s_oc);
        end
      end
      checks++;
      if (s_cnt !== 4'(exp_cnt)) begin
        errors++;
        $display("FAIL skid_stall_cnt: got %0d want %0d",
                 s_cnt, exp_cnt);
      end
      checks++;
      if (p_occ !== 2'(pq.size()) || pq.size() > 1) begin
        errors++;
        $display("FAIL pass_occ: got %0d want %0d",
                 p_occ, pq.size());
      end
      if (p_ov === 1'b0) begin
        checks++;
        if (p_oc !== '0) begin
          errors++;
          $display("FAIL pass_bubble_ctrl: got %h want 0", p_oc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    #3;
    checks++;
    if (s_ov !== 1'b0 || s_od !== '0 || s_oc !== '0 ||
        s_occ !== 2'd0 || s_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_hold: got v%b d%h c%h o%0d n%0d want 0",
               s_ov, s_od, s_oc, s_occ, s_cnt);
    end
    @(negedge CLK);
    #1 RESET = 1'b0;
    tick();
    checks++;
    if (s_ird !== 1'b1 || p_ird !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b/%b want 1/1", s_ird, p_ird);
    end
    s_ord = 1'b0;
    s_iv = 1'b1;
    s_id = DE;
    s_ic = 16'h1234;
    tick();
    s_iv = 1'b0;
    tick();
    tick();
    checks++;
    if (s_cnt !== 4'd2) begin
      errors++;
      $display("FAIL stall_count: got %0d want 2", s_cnt);
    end
    #2 RESET = 1'b1;
    #1;
    checks++;
    if (s_ov !== 1'b0 || s_od !== '0 || s_oc !== '0 ||
        s_occ !== 2'd0 || s_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_async: got v%b d%h c%h o%0d n%0d want 0",
               s_ov, s_od, s_oc, s_occ, s_cnt);
    end
    @(negedge CLK);
    #1 RESET = 1'b0;
  endtask

  task automatic test_stream();
    s_ord = 1'b1;
    s_iv = 1'b1;
    s_id = D0;
    s_ic = 16'h00A5;
    tick();
    checks++;
    if (s_ov !== 1'b1 || s_od !== D0 || s_oc !== 16'h00A5 ||
        s_occ !== 2'd1) begin
      errors++;
      $display("FAIL stream_first: got v%b d%h c%h o%0d want 1/%h/00a5/1",
               s_ov, s_od, s_oc, s_occ, D0);
    end
    for (int i = 1; i <= 8; i++) begin
      s_id = D0 + DW'(i);
      s_ic = 16'(i);
      checks++;
      if (s_ird !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready: got %b want 1 at %0d", s_ird, i);
      end
      tick();
      checks++;
      if (s_od !== D0 + DW'(i)) begin
        errors++;
        $display("FAIL stream_order: got %h want %h",
                 s_od, D0 + DW'(i));
      end
    end
    s_iv = 1'b0;
    tick();
  endtask

  task automatic test_skid_stall();
    s_ord = 1'b0;
    s_iv = 1'b1;
    s_id = DA;
    s_ic = 16'h000A;
    tick();
    s_id = DB;
    s_ic = 16'h000B;
    tick();
    s_id = DC;
    s_ic = 16'h000C;
    checks++;
    if (s_occ !== 2'd2 || s_ird !== 1'b0 || s_od !== DA) begin
      errors++;
      $display("FAIL skid_full: got o%0d r%b d%h want 2/0/%h",
               s_occ, s_ird, s_od, DA);
    end
    tick();
    s_iv = 1'b0;
    checks++;
    if (s_occ !== 2'd2 || s_od !== DA || s_oc !== 16'h000A) begin
      errors++;
      $display("FAIL skid_hold: got o%0d d%h c%h want 2/%h/000a",
               s_occ, s_od, s_oc, DA);
    end
    s_ord = 1'b1;
    tick();
    checks++;
    if (s_ird !== 1'b1 || s_od !== DB || s_occ !== 2'd1) begin
      errors++;
      $display("FAIL skid_drain: got r%b d%h o%0d want 1/%h/1",
               s_ird, s_od, s_occ, DB);
    end
    tick();
    checks++;
    if (s_ov !== 1'b0) begin
      errors++;
      $display("FAIL skid_empty: got %b want 0", s_ov);
    end
  endtask

  task automatic test_flush_full();
    s_ord = 1'b0;
    s_iv = 1'b1;
    s_id = DA;
    s_ic = 16'h000A;
    tick();
    s_id = DB;
    s_ic = 16'h000B;
    tick();
    s_id = DC;
    s_ic = 16'h000C;
    s_flush = 1'b1;
    tick();
    s_flush = 1'b0;
    s_iv = 1'b0;
    checks++;
    if (s_ov !== 1'b0 || s_oc !== '0 || s_occ !== 2'd0 ||
        s_od !== DA) begin
      errors++;
      $display("FAIL flush_full: got v%b c%h o%0d d%h want 0/0/0/%h",
               s_ov, s_oc, s_occ, s_od, DA);
    end
    s_ord = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if (s_ov !== 1'b0) begin
        errors++;
        $display("FAIL flush_leak: got v%b d%h want 0", s_ov, s_od);
      end
    end
    s_iv = 1'b1;
    s_id = DB;
    s_ic = 16'h00BB;
    tick();
    s_id = DC;
    s_flush = 1'b1;
    tick();
    s_flush = 1'b0;
    s_iv = 1'b0;
    checks++;
    if (s_ov !== 1'b0 || s_occ !== 2'd0) begin
      errors++;
      $display("FAIL flush_pop: got v%b o%0d want 0/0", s_ov, s_occ);
    end
  endtask

  task automatic test_bubble();
    s_ord = 1'b1;
    s_iv = 1'b1;
    s_id = DE;
    s_ic = 16'hFFFF;
    tick();
    s_iv = 1'b0;
    checks++;
    if (s_ov !== 1'b1 || s_oc !== 16'hFFFF) begin
      errors++;
      $display("FAIL bubble_load: got v%b c%h want 1/ffff", s_ov, s_oc);
    end
    tick();
    checks++;
    if (s_ov !== 1'b0 || s_oc !== 16'h0000 || s_od !== DE) begin
      errors++;
      $display("FAIL bubble_clear: got v%b c%h d%h want 0/0000/%h",
               s_ov, s_oc, s_od, DE);
    end
  endtask

  task automatic test_stall_sat();
    s_ord = 1'b0;
    s_iv = 1'b1;
    s_id = DA;
    s_ic = 16'h0001;
    tick();
    s_iv = 1'b0;
    repeat (20) tick();
    checks++;
    if (s_cnt !== 4'd15) begin
      errors++;
      $display("FAIL stall_sat: got %0d want 15", s_cnt);
    end
    #2 RESET = 1'b1;
    #1;
    checks++;
    if (s_cnt !== 4'd0 || s_ov !== 1'b0) begin
      errors++;
      $display("FAIL stall_reset: got n%0d v%b want 0/0", s_cnt, s_ov);
    end
    @(negedge CLK);
    #1 RESET = 1'b0;
    s_ord = 1'b1;
    tick();
  endtask

  task automatic test_pass();
    p_ord = 1'b0;
    p_iv = 1'b1;
    p_id = DA;
    p_ic = 16'h0101;
    tick();
    p_id = DB;
    p_ic = 16'h0202;
    #1;
    checks++;
    if (p_ird !== 1'b0) begin
      errors++;
      $display("FAIL pass_block: got %b want 0", p_ird);
    end
    p_ord = 1'b1;
    #1;
    checks++;
    if (p_ird !== 1'b1) begin
      errors++;
      $display("FAIL pass_comb: got %b want 1", p_ird);
    end
    tick();
    checks++;
    if (p_ov !== 1'b1 || p_od !== DB || p_occ !== 2'd1) begin
      errors++;
      $display("FAIL pass_swap: got v%b d%h o%0d want 1/%h/1",
               p_ov, p_od, p_occ, DB);
    end
    repeat (60) begin
      p_iv = 1'($urandom_range(0, 1));
      p_ord = 1'($urandom_range(0, 1));
      p_id = {$urandom, $urandom, $urandom};
      p_ic = 16'($urandom);
      tick();
    end
    p_iv = 1'b0;
    p_ord = 1'b1;
    tick();
    tick();
    checks++;
    if (p_ov !== 1'b0) begin
      errors++;
      $display("FAIL pass_drain: got %b want 0", p_ov);
    end
  endtask

  task automatic test_back_to_back();
    repeat (300) begin
      s_iv = 1'($urandom_range(0, 1));
      s_ord = 1'($urandom_range(0, 2) != 0);
      s_flush = ($urandom_range(0, 15) == 0);
      s_id = {$urandom, $urandom, $urandom};
      s_ic = 16'($urandom);
      tick();
    end
    s_iv = 1'b0;
    s_flush = 1'b0;
    s_ord = 1'b1;
    repeat (3) tick();
    checks++;
    if (s_ov !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain: got %b want 0", s_ov);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid_stall();
    test_flush_full();
    test_bubble();
    test_stall_sat();
    test_pass();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
